// File: rtl/mux_pkg.sv
// Shared mux package: state encodings and a constant-safe clog2.
// Reused by every registered selector in the design.
package mux_pkg;

    typedef logic [1:0] state_t;

    localparam state_t DIRECT     = 2'd0;
    localparam state_t SCAN_DWELL = 2'd1;
    localparam state_t SCAN_HOLD  = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational WIDTH x CHANNELS selector.
// Selects outside the populated range read as zero and raise outOfRange.
module mux_n_comb #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS*WIDTH-1:0] dataIn,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          dataOut,
    output logic                      outOfRange
);

    always_comb begin
        dataOut = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) dataOut = dataIn[k*WIDTH +: WIDTH];
        end
    end

    assign outOfRange = (32'(sel) >= CHANNELS);

endmodule

// File: rtl/scan_mux_n.sv
// Registered N-channel mux: direct select, or self-scanning
// with per-channel dwell and a valid/ready output handshake.
module scan_mux_n
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 8,
    parameter  int DWELL    = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      sysclk,
    input  logic                      sys_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] mux_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          mux_out,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    output logic                      out_err
);

    localparam logic [7:0]       CNT_INIT = 8'(DWELL - 1);
    localparam logic [SEL_W-1:0] CHAN_MAX = SEL_W'(CHANNELS - 1);

    state_t           state, stateN;
    logic [SEL_W-1:0] chan, chanN;
    logic [7:0]       cnt, cntN;
    logic [WIDTH-1:0] muxOutN;
    logic [SEL_W-1:0] outChanN;
    logic             outValidN, outErrN;

    logic [SEL_W-1:0] muxSel;
    logic [WIDTH-1:0] selData;
    logic             selErr;

    // mode low always means a direct capture on this edge
    assign muxSel = mode ? chan : sel;

    mux_n_comb #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) uSel (
        .dataIn     (mux_in),
        .sel        (muxSel),
        .dataOut    (selData),
        .outOfRange (selErr)
    );

    always_comb begin
        stateN    = state;
        chanN     = chan;
        cntN      = cnt;
        muxOutN   = mux_out;
        outChanN  = out_chan;
        outValidN = out_valid;
        outErrN   = out_err;
        if (!mode) begin
            stateN    = DIRECT;
            chanN     = '0;
            cntN      = CNT_INIT;
            muxOutN   = selErr ? '0 : selData;
            outChanN  = sel;
            outValidN = 1'b1;
            outErrN   = selErr;
        end else begin
            unique case (state)
                DIRECT: begin
                    stateN    = SCAN_DWELL;
                    chanN     = '0;
                    cntN      = CNT_INIT;
                    outValidN = 1'b0;
                    outErrN   = 1'b0;
                end
                SCAN_DWELL: begin
                    if (cnt != 8'd0) begin
                        cntN = cnt - 8'd1;
                    end else begin
                        muxOutN   = selData;
                        outChanN  = chan;
                        outValidN = 1'b1;
                        stateN    = SCAN_HOLD;
                    end
                end
                SCAN_HOLD: begin
                    if (out_ready) begin
                        outValidN = 1'b0;
                        chanN     = (chan == CHAN_MAX) ? '0 : chan + 1'b1;
                        cntN      = CNT_INIT;
                        stateN    = SCAN_DWELL;
                    end
                end
                default: stateN = DIRECT;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= DIRECT;
            chan      <= '0;
            cnt       <= CNT_INIT;
            mux_out   <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state     <= stateN;
            chan      <= chanN;
            cnt       <= cntN;
            mux_out   <= muxOutN;
            out_chan  <= outChanN;
            out_valid <= outValidN;
            out_err   <= outErrN;
        end
    end

endmodule

// File: doc/scan_mux_n.md
# scan_mux_n

Parametrised N-channel, W-bit registered multiplexer with two modes.
- **Direct mode:** selects one channel by an external select, with one cycle of latency.
- **Scan mode:** steps through all channels on its own, dwelling a fixed number of cycles on each, and presents each sample through a valid/ready handshake.

It replaces fixed-width 8:1 single-bit selectors wherever a registered, wider or self-scanning source select is needed, for example panel display scanning and debug bus sampling.

## Interface
Parameters:
- WIDTH, default 1: bits per channel, 1..32
- CHANNELS, default 8: number of inputs, 2..16
- DWELL, default 4: cycles spent on each channel in scan mode before capture, 1..255
- SEL_W (localparam) = clog2(CHANNELS)

Ports:
- sysclk  in  1  single clock; all state updates on the rising edge
- sys_rst_n  in  1  reset, asynchronous and active-low
- mux_in  in  CHANNELS*WIDTH  channel k occupies [k*WIDTH +: WIDTH]
- sel  in  SEL_W  channel select, used in direct mode only
- mode  in  1  0 = direct, 1 = scan; sampled every cycle
- out_ready  in  1  consumer accepts the current sample; ignored in direct mode
- mux_out  out  WIDTH  registered selected data
- out_chan  out  SEL_W  channel index that mux_out came from
- out_valid  out  1  mux_out/out_chan are valid
- out_err  out  1  in direct mode, the registered sel was ≥ CHANNELS

## Operation
- States: DIRECT, SCAN_DWELL, SCAN_HOLD. Internal registers: chan (SEL_W bits) and cnt (8 bits).
- Reset (sys_rst_n low, asynchronous): state=DIRECT, chan=0, cnt=DWELL-1, mux_out=0, out_chan=0, out_valid=0, out_err=0.
- **DIRECT, mode=0**, each edge:
  - mux_out<=mux_in[sel], out_chan<=sel, out_valid<=1.
  - out_err<=(sel≥CHANNELS). When out_err is set, mux_out<=0.
- **DIRECT, mode=1**, on the edge:
  - State goes to SCAN_DWELL, with chan<=0, cnt<=DWELL-1.
  - out_valid<=0, out_err<=0. mux_out holds.
- **SCAN_DWELL:**
  - If cnt≠0, cnt decrements.
  - If cnt=0: mux_out<=mux_in[chan], out_chan<=chan, out_valid<=1, state goes to SCAN_HOLD.
- **SCAN_HOLD:**
  - mux_out, out_chan and out_valid stay stable until out_ready=1.
  - On the accepting edge: out_valid<=0, chan<=chan+1, where CHANNELS-1 wraps to 0. cnt<=DWELL-1, state goes to SCAN_DWELL.
- **mode=0 in any scan state:** on the next edge, behave exactly as in DIRECT with mode=0 and enter DIRECT. A pending sample is abandoned, and chan is reset to 0.
- mode takes priority over out_ready when both change in the same cycle.
- Input data is sampled only at the capture edge. Changes to mux_in during dwell are not visible at the output.

## Timing
- Direct latency is 1 cycle: sel/mux_in present before edge n appear on mux_out after edge n.
- Scan mode:
  - mode sampled high at edge e0 → first out_valid high after edge e0+DWELL.
  - Each accepted sample is followed by the next capture DWELL cycles later.
  - With out_ready held high, each channel takes DWELL+1 cycles, so a full wrap takes CHANNELS*(DWELL+1) cycles.
- Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1. out_valid never drops without a transfer, except on a mode change or reset.
- Reset mid-operation takes effect immediately on the outputs. The first edge after release behaves as from reset.

## Structure
- Shared package `mux_pkg`: state encoding localparams (DIRECT=2'd0, SCAN_DWELL=2'd1, SCAN_HOLD=2'd2) and the clog2 function. Other muxes in the design reuse both.
- One sub-module, `mux_n_comb`: purely combinational WIDTH×CHANNELS→WIDTH selector with an out-of-range flag. It is instantiated once and driven by sel or chan according to the state.
- The top level contains the FSM, the dwell counter, the channel counter and the output registers.

## Test plan
All scenarios use CHANNELS=8, WIDTH=4, DWELL=4 unless noted.
1. **Reset:** assert sys_rst_n=0 mid-cycle → mux_out=0, out_chan=0, out_valid=0, out_err=0 asynchronously, before the next edge.
2. **Direct mode:** mode=0, mux_in channel k = k+8, sweep sel 0..7 → after each edge, mux_out=sel+8, out_chan=sel, out_valid=1. With CHANNELS=6 and sel=7 → out_err=1, mux_out=0.
3. **Scan wrap:** mode=1, out_ready=1 → samples 8..15 on out_chan 0..7, then channel 0 again. Accepts are exactly 5 cycles apart, and the first valid is 4 cycles after mode is sampled.
4. **Backpressure:** out_ready=0 for 10 cycles while holding channel 3 → mux_out=11 and out_valid=1 stay stable, and mux_in changes are ignored. Raising out_ready → channel 4 is captured 4 cycles after the accept.
5. **Mode switch in hold:** mode→0 while in SCAN_HOLD on channel 5 with sel=2 → the next edge gives mux_out=10, out_chan=2, out_valid=1. Re-entering scan restarts at channel 0.
6. **Reset mid-scan, DWELL=1:** assert reset mid-scan, release with mode=1 → the first sample is channel 0, valid 1 cycle after mode is sampled.
